// File: rtl/escritor_rtc.sv
// rtl/escritor_rtc.sv - RTC time writer: validates BCD time and writes it over a multiplexed strobe bus.
module escritor_rtc #(
  parameter int          T_SETUP   = 3,
  parameter int          T_PULSO   = 10,
  parameter int          T_HOLD    = 3,
  parameter logic [7:0]  ADDR_SEG  = 8'h21,
  parameter logic [7:0]  ADDR_MIN  = 8'h22,
  parameter logic [7:0]  ADDR_HORA = 8'h23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dato_seg,
  input  logic [7:0] dato_min,
  input  logic [7:0] dato_hora,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] ad,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a_d
);

  localparam int T_MAX0 = (T_SETUP > T_PULSO) ? T_SETUP : T_PULSO;
  localparam int T_MAX  = (T_MAX0 > T_HOLD) ? T_MAX0 : T_HOLD;
  localparam int CW     = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_DONE
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  idx;
  logic [2:0]  nxt;
  logic [7:0]  seg_q, min_q, hora_q;
  logic [7:0]  nxt_word;
  logic        snap_ok;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] vmax);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= vmax);
  endfunction

  assign snap_ok = bcd_ok(seg_q, 8'h59) && bcd_ok(min_q, 8'h59) && bcd_ok(hora_q, 8'h23);
  assign nxt     = idx + 3'd1;
  assign rd_n    = 1'b1;

  // Even bus cycles carry an address, odd ones the matching data byte.
  always_comb begin
    nxt_word = ADDR_SEG;
    case (nxt)
      3'd1:    nxt_word = seg_q;
      3'd2:    nxt_word = ADDR_MIN;
      3'd3:    nxt_word = min_q;
      3'd4:    nxt_word = ADDR_HORA;
      3'd5:    nxt_word = hora_q;
      default: nxt_word = ADDR_SEG;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      seg_q  <= '0;
      min_q  <= '0;
      hora_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      ad     <= 8'h00;
      ad_oe  <= 1'b0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      a_d    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          if (start) begin
            seg_q  <= dato_seg;
            min_q  <= dato_min;
            hora_q <= dato_hora;
            busy   <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!snap_ok) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            idx   <= '0;
            cnt   <= '0;
            cs_n  <= 1'b0;
            ad_oe <= 1'b1;
            ad    <= ADDR_SEG;
            a_d   <= 1'b0;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CW'(T_SETUP - 1)) begin
            cnt   <= '0;
            wr_n  <= 1'b0;
            state <= S_STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STROBE: begin
          if (cnt == CW'(T_PULSO - 1)) begin
            cnt   <= '0;
            wr_n  <= 1'b1;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == CW'(T_HOLD - 1)) begin
            cnt   <= '0;
            cs_n  <= 1'b1;
            ad_oe <= 1'b0;
            ad    <= 8'h00;
            a_d   <= 1'b0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (idx == 3'd5) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx   <= nxt;
            cs_n  <= 1'b0;
            ad_oe <= 1'b1;
            ad    <= nxt_word;
            a_d   <= nxt[0];
            state <= S_SETUP;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_escritor_rtc.sv
// tb/tb_escritor_rtc.sv - Self-checking bench for escritor_rtc against a cycle-offset transaction model.
module tb_escritor_rtc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dato_seg = 8'h00, dato_min = 8'h00, dato_hora = 8'h00;
  logic       busy, done, error, ad_oe, cs_n, wr_n, rd_n, a_d;
  logic [7:0] ad;

  escritor_rtc dut (
    .clk(clk), .reset(reset), .start(start),
    .dato_seg(dato_seg), .dato_min(dato_min), .dato_hora(dato_hora),
    .busy(busy), .done(done), .error(error), .ad(ad), .ad_oe(ad_oe),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a_d(a_d)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: t = cycles since the start-sampling edge; 1000 means idle.
  int         t = 1000;
  bit         ok = 1'b1;
  logic [7:0] wv[6];
  int         cyc_n = 0;

  logic [7:0] wq[$];
  logic       wa[$];
  int         low_runs[$];
  int         done_at[$];
  int         low_run = 0;
  logic       prev_wr = 1'b1;

  function automatic int dec(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit time_ok(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    return dec(s) >= 0 && dec(s) <= 59 && dec(m) >= 0 && dec(m) <= 59 && dec(h) >= 0 && dec(h) <= 23;
  endfunction

  // {busy,done,error,cs_n,wr_n,rd_n,a_d,ad_oe,ad}
  function automatic logic [15:0] expv(input int tt, input bit okk);
    logic [15:0] idle_v;
    int b, p;
    idle_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    if (tt == 0) return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    if (!okk) begin
      if (tt == 1) return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      return idle_v;
    end
    if (tt >= 1 && tt <= 102) begin
      b = (tt - 1) / 17;
      p = (tt - 1) % 17;
      if (p == 16) return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      return {1'b1, 1'b0, 1'b0, 1'b0, !(p >= 3 && p < 13), 1'b1, 1'(b % 2), 1'b1, wv[b]};
    end
    if (tt == 103) return {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    return idle_v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc_n, got, exp_v);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
    end
  endtask

  function automatic logic [15:0] dut_v();
    return {busy, done, error, cs_n, wr_n, rd_n, a_d, ad_oe, ad};
  endfunction

  task automatic step();
    bit in_idle;
    @(posedge clk);
    cyc_n++;
    if (!reset) begin
      t = 1000;
    end else begin
      in_idle = ok ? (t >= 104) : (t >= 1);
      if (in_idle) begin
        if (start) begin
          wv[0] = 8'h21; wv[1] = dato_seg;
          wv[2] = 8'h22; wv[3] = dato_min;
          wv[4] = 8'h23; wv[5] = dato_hora;
          ok = time_ok(dato_seg, dato_min, dato_hora);
          t  = 0;
        end else begin
          t = 1000;
        end
      end else begin
        t++;
      end
    end
    @(negedge clk);
    chk("outputs", dut_v(), expv(t, ok));
    if (wr_n == 1'b0 && prev_wr == 1'b1) begin
      wq.push_back(ad);
      wa.push_back(a_d);
      low_run = 1;
    end else if (wr_n == 1'b0) begin
      low_run++;
    end else if (prev_wr == 1'b0) begin
      low_runs.push_back(low_run);
    end
    if (done) done_at.push_back(cyc_n);
    prev_wr = wr_n;
  endtask

  task automatic clear_logs();
    wq.delete(); wa.delete(); low_runs.delete(); done_at.delete();
  endtask

  function automatic logic [7:0] rnd_bcd(input int maxv);
    int v;
    v = $urandom_range(0, maxv);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    logic [7:0] exp_bus[6];
    int k;
    int n_low;
    exp_bus[0] = 8'h21; exp_bus[1] = 8'h45; exp_bus[2] = 8'h22;
    exp_bus[3] = 8'h30; exp_bus[4] = 8'h23; exp_bus[5] = 8'h12;

    // Reset state
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    // Known values; inputs cleared right after start to prove the snapshot
    clear_logs();
    dato_seg = 8'h45; dato_min = 8'h30; dato_hora = 8'h12; start = 1'b1;
    step();
    k = cyc_n;
    start = 1'b0; dato_seg = 8'h00; dato_min = 8'h00; dato_hora = 8'h00;
    repeat (110) step();
    chk_int("write_count", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      chk("bus_word", {8'h00, wq[i]}, {8'h00, exp_bus[i]});
      chk("bus_a_d", {15'h0, wa[i]}, {15'h0, 1'(i % 2)});
    end
    for (int i = 0; i < low_runs.size(); i++) chk_int("wr_low_len", low_runs[i], 10);
    chk_int("done_count", done_at.size(), 1);
    if (done_at.size() > 0) chk_int("done_latency", done_at[0] - k, 103);

    // Out-of-range hour
    clear_logs();
    dato_seg = 8'h10; dato_min = 8'h10; dato_hora = 8'h24; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("err_pulse", {14'h0, error, busy}, {14'h0, 1'b1, 1'b0});
    repeat (4) step();
    chk_int("err_no_cs", wq.size(), 0);

    // Non-BCD seconds
    dato_seg = 8'h5A; dato_min = 8'h00; dato_hora = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk_int("nibble_no_wr", low_runs.size() + wq.size(), 0);

    // Reset during data-MIN strobe, then a fresh full write
    dato_seg = 8'h01; dato_min = 8'h02; dato_hora = 8'h03; start = 1'b1;
    step();
    start = 1'b0;
    repeat (60) step();
    chk("pre_reset_strobe", {15'h0, wr_n}, 16'h0);
    reset = 1'b0;
    #1;
    t = 1000;
    chk("reset_mid", {busy, cs_n, wr_n, ad_oe}, {12'h0, 4'b0110});
    chk("reset_mid_all", dut_v(), expv(1000, 1'b1));
    repeat (2) step();
    reset = 1'b1;
    prev_wr = wr_n;
    clear_logs();
    dato_seg = 8'h45; dato_min = 8'h30; dato_hora = 8'h12; start = 1'b1;
    step();
    start = 1'b0;
    repeat (110) step();
    chk_int("rewrite_count", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++) chk("rewrite_word", {8'h00, wq[i]}, {8'h00, exp_bus[i]});

    // start held high: back-to-back transactions
    clear_logs();
    start = 1'b1;
    repeat (300) step();
    start = 1'b0;
    repeat (110) step();
    chk_int("b2b_min_done", int'(done_at.size() >= 2), 1);
    for (int i = 1; i < done_at.size(); i++) chk_int("b2b_period", done_at[i] - done_at[i-1], 105);

    // Randomized traffic
    n_low = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) begin
        dato_seg = rnd_bcd(59); dato_min = rnd_bcd(59); dato_hora = rnd_bcd(23);
      end else begin
        dato_seg = 8'($urandom); dato_min = rnd_bcd(59); dato_hora = 8'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0; n_low++;
        #1;
        t = 1000;
        chk("rand_reset", dut_v(), expv(1000, 1'b1));
      end else begin
        reset = 1'b1;
      end
      step();
      prev_wr = wr_n;
    end
    reset = 1'b1;
    start = 1'b0;
    repeat (110) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/escritor_rtc.md
ESCRITOR_RTC -- requirements
Module: escritor_rtc

Interface
REQ-001 Parameter T_SETUP, default 3, SHALL set the clocks from bus drive to strobe fall.
REQ-002 Parameter T_PULSO, default 10, SHALL set the clocks wr_n is held low.
REQ-003 Parameter T_HOLD, default 3, SHALL set the clocks bus is held after strobe rise.
REQ-004 Parameters ADDR_SEG/ADDR_MIN/ADDR_HORA, defaults 8'h21/8'h22/8'h23, SHALL be the RTC register addresses.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  write request, level sampled each clk.
REQ-008 dato_seg, dato_min, dato_hora  in  8 each  BCD values from the editing adders.
REQ-009 busy  out  1  transaction in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 error  out  1  one-cycle invalid-BCD pulse.
REQ-012 ad  out  8  multiplexed address/data bus value; ad_oe  out  1  bus drive enable (tristate at top level).
REQ-013 cs_n, wr_n, rd_n, a_d  out  1 each  RTC strobes; a_d=0 address phase, 1 data phase.

Function
REQ-014 States SHALL be IDLE, CHECK, SETUP, STROBE, HOLD, GAP, DONE.
REQ-015 In IDLE, start=1 at an edge SHALL snapshot all three inputs, set busy=1 and enter CHECK; inputs are ignored thereafter until IDLE.
REQ-016 CHECK SHALL validate every nibble <=9, seg<=8'h59, min<=8'h59, hora<=8'h23; on failure SHALL pulse error one cycle, clear busy, return to IDLE with no bus activity.
REQ-017 On pass, six bus cycles SHALL run in order: addr SEG, data SEG, addr MIN, data MIN, addr HORA, data HORA.
REQ-018 Each bus cycle SHALL be SETUP (T_SETUP clks: cs_n=0, ad_oe=1, ad and a_d valid, wr_n=1), STROBE (T_PULSO clks: wr_n=0), HOLD (T_HOLD clks: wr_n=1, ad/a_d/cs_n unchanged), GAP (1 clk: cs_n=1, ad_oe=0).
REQ-019 ad and a_d SHALL be stable throughout SETUP, STROBE and HOLD of a bus cycle.
REQ-020 rd_n SHALL be constantly 1.
REQ-021 After the sixth GAP, DONE SHALL last one cycle with done=1, busy=1, then IDLE with busy=0.
REQ-022 With start sampled at edge k and defaults, first SETUP SHALL begin after edge k+1, done SHALL be high after edge k+103, busy low after edge k+104.
REQ-023 start held high SHALL not retrigger before IDLE; if still high in IDLE a new transaction SHALL begin.
REQ-024 done and error SHALL never be high simultaneously.
REQ-025 Phase counter SHALL be wide enough for max(T_SETUP,T_PULSO,T_HOLD) and SHALL not wrap mid-phase.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, busy=0, done=0, error=0, cs_n=1, wr_n=1, rd_n=1, a_d=0, ad=8'h00, ad_oe=0, including mid-transaction; no resume after release.

Verification
REQ-027 seg=8'h45, min=8'h30, hora=8'h12, start one clk -> bus sees 21/45/22/30/23/12 with a_d 0/1 alternating, wr_n low 10 clks each, done after edge k+103.
REQ-028 hora=8'h24, start -> error pulse one cycle, cs_n stays 1, busy low after two edges.
REQ-029 seg=8'h5A -> error pulse, no wr_n activity.
REQ-030 Inputs changed to 8'h00 during transaction -> written values remain snapshot values.
REQ-031 reset=0 during STROBE of data MIN -> same cycle wr_n=1, cs_n=1, ad_oe=0, busy=0; next start writes all three from scratch.
REQ-032 start held high 300 clks -> back-to-back transactions, each preceded by IDLE cycle, done pulses 105 clks apart.
